core_ready_queue: RTL
=====================

# core_ready_queue

Parametrised FIFO of core IDs that are ready for dispatch, the multi-port successor of the single-port core queue. Up to `PORTS` requesters may enqueue core IDs in the same cycle. Each core ID is held at most once, so duplicate requests are suppressed and the queue can never overflow. The scheduler reads the head ID (`current_id`/`current_valid`) and pops it with `current_consume`.

## Interface
- `CORES`, 4, number of cores; IDs are 0..CORES-1; any value ≥2, not required to be a power of two
- `PORTS`, 2, number of enqueue ports; ≥1
- `IDW`, `$clog2(CORES)`, ID width (derived, do not override)
- `CNTW`, `$clog2(CORES+1)`, count width (derived)

Ports:
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  synchronous reset, active-low
- `enqueue_id`  in  PORTS×IDW  packed array; port p is bits [p*IDW +: IDW]
- `enqueue_valid`  in  PORTS  per-port enqueue request
- `current_id`  out  IDW  head entry
- `current_valid`  out  1  queue non-empty
- `current_consume`  in  1  pop head this cycle
- `count`  out  CNTW  number of queued entries, 0..CORES
- `pending`  out  CORES  bit i set while ID i is queued
- `dup_drop`  out  1  one-cycle pulse: at least one request was suppressed in the previous cycle

## Operation
- Storage: circular buffer of CORES entries with `head` and `tail` pointers, both in 0..CORES-1. Pointers wrap explicitly from CORES-1 to 0 (no modulo-2^n assumption).
- Per-cycle update order within one edge:
  - (1) Pop. The pop happens iff `current_consume && current_valid`: head advances by 1, `pending[head_id]` clears, `count` decrements. `current_consume` while empty is ignored.
  - (2) Enqueue, ports in ascending index order (port 0 first). Request p is accepted iff `enqueue_valid[p]` is set, its ID is < CORES, the ID is not pending after step 1, and the ID is not accepted by a lower port in this cycle.
  - Accepted IDs are written at `tail`, `tail+1`, … in port order; `tail` advances by the number accepted; the matching `pending` bits are set.
  - Rejected valid requests, whether duplicates or out-of-range IDs, set `dup_drop` on the next cycle.
- `count_next = count - pop + accepted`, always ≤ CORES. Overflow is impossible by construction; no full flag exists.
- Consequence of the order: popping ID k and enqueuing k in the same cycle re-queues k at the tail.
- `current_id` is `buffer[head]`. It is don't-care while `current_valid` = 0; the bench must not check it then.
- Reset (`reset_n` = 0 at an edge):
  - `head`, `tail`, `count`, `pending`, `dup_drop` ← 0, so `current_valid` = 0.
  - `current_id` reads 0; buffer contents are don't-care.
  - Reset overrides consume and enqueue in the same cycle.
  - Reset mid-operation discards all queued IDs.

## Timing
- All outputs are registered or decoded purely from registered state; there is no combinational path from inputs to outputs.
- Enqueue latency: a request accepted at edge N makes `current_valid`/`count` reflect it from edge N onward, i.e. visible in cycle N+1.
- Pop latency: the new head is presented in the cycle after the consume edge.
- Back-to-back consume is supported every cycle, giving 1 pop/cycle throughput.
- Enqueue throughput is up to PORTS IDs per cycle.
- `dup_drop` is high for exactly one cycle per cycle that contained a rejection.

## Test plan
- Reset, then ports 0/1 = IDs 0/1 at edge 10, then port 0 = ID 2 at edge 12:
  - `count` goes 2 then 3; `pending` = 4'b0111.
  - Successive consumes return 0, 1, 2, then `current_valid` = 0 and `count` = 0.
- Same-cycle duplicate: ports 0 and 1 both request ID 3 while empty → one entry, `count` = 1, `dup_drop` pulses once.
- Already pending: queue holds {1}; enqueue ID 1 → `count` stays 1, `dup_drop` = 1; order unchanged.
- Pop and re-enqueue head: queue {0, 2}; consume and enqueue 0 in the same cycle → queue becomes {2, 0}, `count` stays 2.
- Wrap and full, CORES = 4:
  - Fill IDs 3, 0, 1, 2 → `count` = 4.
  - Pop 2, enqueue 3, 0, pop 4 → output order 3, 0, 1, 2, 3, 0 with `count` correct at every step.
  - Consume while empty is ignored: `count` stays 0.
- Reset mid-operation: with `count` = 3, assert `reset_n` = 0 for one cycle alongside an enqueue and a consume → `count` = 0, `pending` = 0, `current_valid` = 0, `dup_drop` = 0.

Source files
------------

// File: rtl/core_ready_queue_if.sv
// Handshake bundle between enqueue requesters / scheduler (master) and the ready queue (slave).
interface core_ready_queue_if #(
  parameter int CORES = 4,
  parameter int PORTS = 2
);
  localparam int IDW  = $clog2(CORES);
  localparam int CNTW = $clog2(CORES + 1);

  logic [PORTS*IDW-1:0] enqueue_id;
  logic [PORTS-1:0]     enqueue_valid;
  logic [IDW-1:0]       current_id;
  logic                 current_valid;
  logic                 current_consume;
  logic [CNTW-1:0]      count;
  logic [CORES-1:0]     pending;
  logic                 dup_drop;

  modport master (
    output enqueue_id, enqueue_valid, current_consume,
    input  current_id, current_valid, count, pending, dup_drop
  );

  modport slave (
    input  enqueue_id, enqueue_valid, current_consume,
    output current_id, current_valid, count, pending, dup_drop
  );
endinterface

// File: rtl/core_ready_queue.sv
// Multi-port FIFO of ready core IDs; each ID is held at most once, so the queue cannot overflow.
module core_ready_queue #(
  parameter int CORES = 4,
  parameter int PORTS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  core_ready_queue_if.slave  q_if
);
  localparam int IDW  = $clog2(CORES);
  localparam int CNTW = $clog2(CORES + 1);

  logic [IDW-1:0]   buffer_q [CORES];
  logic [IDW-1:0]   buffer_d [CORES];
  logic [IDW-1:0]   head_q, head_d;
  logic [IDW-1:0]   tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [CORES-1:0] pending_q, pending_d;
  logic             dup_drop_q, dup_drop_d;

  logic             pop;
  logic [IDW-1:0]   req_id;
  logic [IDW-1:0]   wr_ptr;
  logic [CNTW-1:0]  acc_cnt;
  logic             reject;

  // CORES need not be a power of two, so pointers wrap explicitly.
  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] ptr);
    return (ptr == IDW'(CORES - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    buffer_d   = buffer_q;
    head_d     = head_q;
    pending_d  = pending_q;
    wr_ptr     = tail_q;
    acc_cnt    = '0;
    reject     = 1'b0;
    req_id     = '0;
    pop        = q_if.current_consume && (count_q != '0);

    if (pop) begin
      pending_d[buffer_q[head_q]] = 1'b0;
      head_d = ptr_inc(head_q);
    end

    // Pending bits are updated per accepted port, which also suppresses same-cycle duplicates.
    for (int p = 0; p < PORTS; p++) begin
      req_id = q_if.enqueue_id[p*IDW +: IDW];
      if (q_if.enqueue_valid[p]) begin
        if ((CNTW'(req_id) < CNTW'(CORES)) && !pending_d[req_id]) begin
          pending_d[req_id] = 1'b1;
          buffer_d[wr_ptr]  = req_id;
          wr_ptr            = ptr_inc(wr_ptr);
          acc_cnt           = acc_cnt + 1'b1;
        end else begin
          reject = 1'b1;
        end
      end
    end

    tail_d     = wr_ptr;
    count_d    = count_q - CNTW'(pop) + acc_cnt;
    dup_drop_d = reject;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      dup_drop_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      dup_drop_q <= dup_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    buffer_q <= buffer_d;
  end

  assign q_if.current_valid = (count_q != '0);
  assign q_if.current_id    = q_if.current_valid ? buffer_q[head_q] : '0;
  assign q_if.count         = count_q;
  assign q_if.pending       = pending_q;
  assign q_if.dup_drop      = dup_drop_q;
endmodule
